// File: rtl/rom_dl_sequencer.sv
// Transmit side of the DLROM download bus: buffers an incoming byte stream and replays it as paced
// single-cycle ROMEN strobes at sequential ROMAD addresses, holding the game in reset until loaded.
module rom_dl_sequencer #(
  parameter int unsigned IMG_SIZE = 79360,
  parameter int unsigned FIFO_LG2 = 2,
  parameter int unsigned WR_GAP   = 2
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        IN_VALID,
  input  logic [7:0]  IN_DATA,
  output logic        IN_READY,
  output logic [16:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVERRUN,
  output logic [15:0] CHKSUM,
  output logic        GAME_RST
);

  localparam int unsigned       Depth    = 1 << FIFO_LG2;
  localparam logic [FIFO_LG2:0] DepthCnt = (FIFO_LG2 + 1)'(Depth);
  localparam logic [16:0]       LastAddr = 17'(IMG_SIZE - 1);
  localparam logic [2:0]        GapLast  = 3'(WR_GAP - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
  typedef enum logic [1:0] {EngWait, EngStrobe, EngGap} eng_e;

  state_e              state_q, state_d;
  eng_e                eng_q, eng_d;
  logic [2:0]          gap_cnt_q, gap_cnt_d;
  logic [16:0]         romad_q, romad_d;
  logic [7:0]          romdt_q, romdt_d;
  logic [15:0]         chksum_q, chksum_d;
  logic                overrun_q, overrun_d;
  logic                game_rst_q, game_rst_d;
  logic                in_ready_q, in_ready_d;
  logic [FIFO_LG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LG2:0]   count_q, count_d;
  logic [7:0]          mem_q [Depth];

  logic push, pop, finish;

  // A byte offered alongside START belongs to no download, so the handshake is suppressed.
  assign IN_READY = in_ready_q & ~START;
  assign push     = IN_VALID & IN_READY & (state_q == StLoad);
  assign pop      = (state_q == StLoad) & (eng_q == EngWait) & (count_q != '0);

  always_comb begin
    state_d   = state_q;
    eng_d     = eng_q;
    gap_cnt_d = gap_cnt_q;
    romad_d   = romad_q;
    romdt_d   = romdt_q;
    chksum_d  = chksum_q;
    overrun_d = overrun_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    finish    = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      romdt_d  = mem_q[rd_ptr_q];
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    if (state_q == StLoad) begin
      unique case (eng_q)
        EngWait: if (pop) eng_d = EngStrobe;
        EngStrobe: begin
          chksum_d = chksum_q + {8'h00, romdt_q};
          if (WR_GAP == 0) begin
            finish = 1'b1;
          end else begin
            eng_d     = EngGap;
            gap_cnt_d = '0;
          end
        end
        EngGap: begin
          if (gap_cnt_q == GapLast) finish = 1'b1;
          else gap_cnt_d = gap_cnt_q + 1'b1;
        end
        default: eng_d = EngWait;
      endcase
    end

    if (finish) begin
      eng_d = EngWait;
      if (romad_q == LastAddr) begin
        state_d = StDone;
        // Bytes still buffered have no address left to go to: drop them and flag it.
        if (count_d != '0) overrun_d = 1'b1;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        romad_d = romad_q + 17'd1;
      end
    end

    if ((state_q == StDone) && IN_VALID && IN_READY) overrun_d = 1'b1;

    if (START) begin
      state_d   = StLoad;
      eng_d     = EngWait;
      gap_cnt_d = '0;
      romad_d   = '0;
      romdt_d   = '0;
      chksum_d  = '0;
      overrun_d = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end

    game_rst_d = START | (state_q != StDone);

    case (state_d)
      StLoad:  in_ready_d = (count_d != DepthCnt);
      StDone:  in_ready_d = 1'b1;
      default: in_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      eng_q      <= EngWait;
      gap_cnt_q  <= '0;
      romad_q    <= '0;
      romdt_q    <= '0;
      chksum_q   <= '0;
      overrun_q  <= 1'b0;
      game_rst_q <= 1'b1;
      in_ready_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      eng_q      <= eng_d;
      gap_cnt_q  <= gap_cnt_d;
      romad_q    <= romad_d;
      romdt_q    <= romdt_d;
      chksum_q   <= chksum_d;
      overrun_q  <= overrun_d;
      game_rst_q <= game_rst_d;
      in_ready_q <= in_ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge MCLK) begin
    if (push) mem_q[wr_ptr_q] <= IN_DATA;
  end

  assign ROMAD    = romad_q;
  assign ROMDT    = romdt_q;
  assign ROMEN    = (eng_q == EngStrobe);
  assign BUSY     = (state_q == StLoad);
  assign DONE     = (state_q == StDone);
  assign OVERRUN  = overrun_q;
  assign CHKSUM   = chksum_q;
  assign GAME_RST = game_rst_q;

endmodule
